// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: ALU codes,
// opcodes, ALU-op classes, controller states and mux select values.
package riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTER = 4'd6,
        ST_EXECUTEI = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_JAL      = 4'd9,
        ST_BEQ      = 4'd10,
        ST_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC  = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT   = 2'b00;
    localparam logic [1:0] RES_DATA     = 2'b01;
    localparam logic [1:0] RES_ALURES   = 2'b10;

    localparam logic [1:0] IMM_I        = 2'b00;
    localparam logic [1:0] IMM_S        = 2'b01;
    localparam logic [1:0] IMM_B        = 2'b10;
    localparam logic [1:0] IMM_J        = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU-op class plus instruction fields to an ALU control code.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // ALU control selection; sub only for R-type with funct7[5] set
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback over a shared memory with a mem_ready handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 -> PC when memory ready
// DECODE   | read registers, OldPC+imm -> ALUOut (branch target)
// MEMADR   | rs1+imm -> ALUOut (load/store address)
// MEMREAD  | read data memory at ALUOut, wait for mem_ready
// MEMWB    | loaded data -> rd
// MEMWRITE | write data memory at ALUOut, held until mem_ready
// EXECUTER | rs1 op rs2
// EXECUTEI | rs1 op imm
// ALUWB    | ALUOut -> rd
// JAL      | OldPC+4 -> ALUOut, jump target -> PC
// BEQ      | rs1-rs2, take branch target when zero
// ILLEGAL  | unsupported opcode, parked until reset
module mc_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_control,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       illegal
);

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       mem_write_raw;

    // State register; reset returns to FETCH asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; mem_ready only matters in the memory-access states
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:    if (mem_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = ST_MEMADR;
                    OP_RTYPE:          state_next = ST_EXECUTER;
                    OP_ITYPE:          state_next = ST_EXECUTEI;
                    OP_JAL:            state_next = ST_JAL;
                    OP_BEQ:            state_next = ST_BEQ;
                    default:           state_next = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR:   state_next = op[5] ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (mem_ready) state_next = ST_MEMWB;
            ST_MEMWB:    state_next = ST_FETCH;
            ST_MEMWRITE: if (mem_ready) state_next = ST_FETCH;
            ST_EXECUTER: state_next = ST_ALUWB;
            ST_EXECUTEI: state_next = ST_ALUWB;
            ST_ALUWB:    state_next = ST_FETCH;
            ST_JAL:      state_next = ST_ALUWB;
            ST_BEQ:      state_next = ST_FETCH;
            ST_ILLEGAL:  state_next = ST_ILLEGAL;
            default:     state_next = ST_FETCH;
        endcase
    end

    // Moore outputs per state, before reset gating of the enables
    always_comb begin
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        result_src    = RES_ALUOUT;
        adr_src       = 1'b0;
        alu_op        = ALUOP_ADD;
        ir_write_raw  = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        illegal       = 1'b0;
        case (state)
            ST_FETCH: begin
                alu_src_b    = SRC_B_FOUR;
                result_src   = RES_ALURES;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEMREAD: begin
                adr_src = 1'b1;
            end
            ST_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
            end
            ST_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            ST_EXECUTER: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_EXECUTEI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            ST_JAL: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_FOUR;
                pc_update = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            ST_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                alu_src_a = SRC_A_PC;
            end
        endcase
    end

    // Enables are held low combinationally for as long as reset is asserted
    always_comb begin
        ir_write  = ir_write_raw & rst_n;
        pc_write  = (pc_update | (branch & zero)) & rst_n;
        reg_write = reg_write_raw & rst_n;
        mem_write = mem_write_raw & rst_n;
    end

    // Immediate format follows the opcode directly
    always_comb begin
        case (op)
            OP_STORE: imm_src = IMM_S;
            OP_BEQ:   imm_src = IMM_B;
            OP_JAL:   imm_src = IMM_J;
            default:  imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each step names the state the controller
// should be in, a reference model derives the expected outputs from that
// state and the driven inputs, and the result is queued then checked.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alu_control;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .alu_control (alu_control),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .illegal     (illegal)
    );

    typedef enum int {
        T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
        T_EXECR, T_EXECI, T_ALUWB, T_JAL, T_BEQ, T_ILLEGAL
    } tstate_t;

    int          checks   = 0;
    int          failures = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mask_q[$];
    string       tag_q[$];

    function automatic logic [2:0] ref_alu(input logic [1:0] aluop, input logic [2:0] f3,
                                           input logic op5, input logic f7);
        if (aluop == 2'b01) return 3'b001;
        if (aluop != 2'b10) return 3'b000;
        case (f3)
            3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // Vector layout: {alu_control, src_a, src_b, result_src, imm_src, adr_src,
    //                 ir_write, pc_write, reg_write, mem_write, illegal}
    function automatic void ref_model(input tstate_t st, output logic [16:0] e,
                                      output logic [16:0] m);
        logic [2:0] ac;
        logic [1:0] a, b, rs;
        logic       adr, ir, pc, rw, mw, ill;
        logic       mac, mab, mrs, madr, mimm;
        ac = 3'b000; a = 2'b00; b = 2'b00; rs = 2'b00; adr = 1'b0;
        ir = 1'b0; pc = 1'b0; rw = 1'b0; mw = 1'b0; ill = 1'b0;
        mac = 1'b1; mab = 1'b1; mrs = 1'b1; madr = 1'b1; mimm = 1'b1;
        case (st)
            T_RST:      begin mac = 0; mab = 0; mrs = 0; madr = 0; mimm = 0; end
            T_FETCH:    begin b = 2'b10; rs = 2'b10; ir = mem_ready; pc = mem_ready; end
            T_DECODE:   begin a = 2'b01; b = 2'b01; mrs = 0; madr = 0; end
            T_MEMADR:   begin a = 2'b10; b = 2'b01; mrs = 0; madr = 0; end
            T_MEMREAD:  begin adr = 1; mac = 0; mab = 0; end
            T_MEMWB:    begin rs = 2'b01; rw = 1; mac = 0; mab = 0; madr = 0; end
            T_MEMWRITE: begin adr = 1; mw = 1; mac = 0; mab = 0; end
            T_EXECR:    begin a = 2'b10; ac = ref_alu(2'b10, funct3, op[5], funct7b5);
                              mrs = 0; madr = 0; end
            T_EXECI:    begin a = 2'b10; b = 2'b01; ac = ref_alu(2'b10, funct3, op[5], funct7b5);
                              mrs = 0; madr = 0; end
            T_ALUWB:    begin rw = 1; mac = 0; mab = 0; madr = 0; end
            T_JAL:      begin a = 2'b01; b = 2'b10; pc = 1; madr = 0; end
            T_BEQ:      begin a = 2'b10; ac = ref_alu(2'b01, funct3, op[5], funct7b5);
                              pc = zero; madr = 0; end
            T_ILLEGAL:  begin ill = 1; mac = 0; mab = 0; mrs = 0; madr = 0; end
            default:    begin mac = 0; end
        endcase
        e = {ac, a, b, rs, ref_imm(op), adr, ir, pc, rw, mw, ill};
        m = {{3{mac}}, {4{mab}}, {2{mrs}}, {2{mimm}}, madr, 5'b11111};
    endfunction

    task automatic push_exp(input string tag, input tstate_t st);
        logic [16:0] e, m;
        ref_model(st, e, m);
        exp_q.push_back(e);
        mask_q.push_back(m);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        logic [16:0] e, m, obs;
        string       tag;
        e   = exp_q.pop_front();
        m   = mask_q.pop_front();
        tag = tag_q.pop_front();
        obs = {alu_control, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, illegal};
        checks++;
        assert ((obs & m) === (e & m)) else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h mask=%05h", tag, obs, e, m);
        end
    endtask

    task automatic check_now(input string tag, input tstate_t st);
        push_exp(tag, st);
        pop_check();
    endtask

    // Expectation queued with the current inputs, checked mid-cycle, then
    // advance to just after the next rising edge.
    task automatic step(input string tag, input tstate_t st);
        push_exp(tag, st);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b1;
        zero = 1'b1;
        set_instr(7'b0110011, 3'b000, 1'b1);
        @(posedge clk);
        #1;
        step("rst_hold0", T_RST);
        step("rst_hold1", T_RST);

        // R-type sub, zero held high to show it is ignored outside BEQ
        rst_n = 1'b1;
        step("r_fetch", T_FETCH);
        step("r_decode", T_DECODE);
        step("r_exec_sub", T_EXECR);
        step("r_aluwb", T_ALUWB);

        // lw with two stall cycles in MEMREAD
        zero = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0);
        step("lw_fetch", T_FETCH);
        step("lw_decode", T_DECODE);
        step("lw_memadr", T_MEMADR);
        mem_ready = 1'b0;
        step("lw_memread_stall0", T_MEMREAD);
        step("lw_memread_stall1", T_MEMREAD);
        mem_ready = 1'b1;
        step("lw_memread_done", T_MEMREAD);
        step("lw_memwb", T_MEMWB);

        // sw with a fetch stall and a held write
        set_instr(7'b0100011, 3'b010, 1'b0);
        mem_ready = 1'b0;
        step("sw_fetch_stall", T_FETCH);
        mem_ready = 1'b1;
        step("sw_fetch", T_FETCH);
        step("sw_decode", T_DECODE);
        step("sw_memadr", T_MEMADR);
        mem_ready = 1'b0;
        step("sw_memwrite_stall0", T_MEMWRITE);
        step("sw_memwrite_stall1", T_MEMWRITE);
        mem_ready = 1'b1;
        step("sw_memwrite_done", T_MEMWRITE);

        // beq taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        zero = 1'b1;
        step("beq1_fetch", T_FETCH);
        step("beq1_decode", T_DECODE);
        step("beq1_taken", T_BEQ);

        // beq not taken; mem_ready low in DECODE must not stall
        zero = 1'b0;
        step("beq0_fetch", T_FETCH);
        mem_ready = 1'b0;
        step("beq0_decode", T_DECODE);
        mem_ready = 1'b1;
        step("beq0_not_taken", T_BEQ);

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        step("jal_fetch", T_FETCH);
        step("jal_decode", T_DECODE);
        step("jal_jump", T_JAL);
        step("jal_aluwb", T_ALUWB);

        // I-type ALU ops with funct7b5 set: addi, ori, andi, slti
        set_instr(7'b0010011, 3'b000, 1'b1);
        step("addi_fetch", T_FETCH);
        step("addi_decode", T_DECODE);
        step("addi_exec", T_EXECI);
        step("addi_aluwb", T_ALUWB);
        set_instr(7'b0010011, 3'b110, 1'b1);
        step("ori_fetch", T_FETCH);
        step("ori_decode", T_DECODE);
        step("ori_exec", T_EXECI);
        step("ori_aluwb", T_ALUWB);
        set_instr(7'b0010011, 3'b111, 1'b1);
        step("andi_fetch", T_FETCH);
        step("andi_decode", T_DECODE);
        step("andi_exec", T_EXECI);
        step("andi_aluwb", T_ALUWB);
        set_instr(7'b0010011, 3'b010, 1'b1);
        step("slti_fetch", T_FETCH);
        step("slti_decode", T_DECODE);
        step("slti_exec", T_EXECI);
        step("slti_aluwb", T_ALUWB);

        // R-type and/or/slt
        set_instr(7'b0110011, 3'b111, 1'b0);
        step("and_fetch", T_FETCH);
        step("and_decode", T_DECODE);
        step("and_exec", T_EXECR);
        step("and_aluwb", T_ALUWB);
        set_instr(7'b0110011, 3'b010, 1'b0);
        step("slt_fetch", T_FETCH);
        step("slt_decode", T_DECODE);
        step("slt_exec", T_EXECR);
        step("slt_aluwb", T_ALUWB);

        // Illegal opcode parks the controller
        set_instr(7'b0000000, 3'b000, 1'b0);
        step("ill_fetch", T_FETCH);
        step("ill_decode", T_DECODE);
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            zero = ~i[0];
            step($sformatf("ill_hold%0d", i), T_ILLEGAL);
        end
        mem_ready = 1'b1;
        zero = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_now("ill_reset", T_RST);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_instr(7'b0000011, 3'b010, 1'b0);
        step("post_ill_fetch", T_FETCH);
        step("post_ill_decode", T_DECODE);

        // Reset asserted in the middle of MEMADR
        #1;
        check_now("mid_memadr", T_MEMADR);
        rst_n = 1'b0;
        #1;
        check_now("mid_memadr_reset", T_RST);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("after_reset_fetch", T_FETCH);
        step("after_reset_decode", T_DECODE);
        step("after_reset_memadr", T_MEMADR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RISC-V datapath. It is the driving end of the ALU's `alu_control`/`zero` interface. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback, and decodes `op`/`funct3`/`funct7b5` into ALU operations. It sequences the shared instruction/data memory through a `mem_ready` handshake and gates the PC, IR, register-file and memory write enables.

## Interface
- No parameters.
- `clk` — in — 1 — rising-edge clock.
- `rst_n` — in — 1 — reset, asynchronous, active-low.
- `op` — in — 7 — opcode from the IR.
- `funct3` — in — 3 — `instr[14:12]`.
- `funct7b5` — in — 1 — `instr[30]`.
- `zero` — in — 1 — ALU zero flag.
- `mem_ready` — in — 1 — memory access completes this cycle.
- `alu_control` — out — 3 — ALU control code:
  - `000` add
  - `001` sub
  - `010` and
  - `011` or
  - `101` slt
- `alu_src_a` — out — 2 — ALU operand A select: `00` PC, `01` OldPC, `10` rs1.
- `alu_src_b` — out — 2 — ALU operand B select: `00` rs2, `01` imm, `10` constant 4.
- `result_src` — out — 2 — result select: `00` ALUOut, `01` Data, `10` ALU result.
- `imm_src` — out — 2 — immediate format: `00` I, `01` S, `10` B, `11` J.
- `adr_src` — out — 1 — memory address select: `0` PC, `1` ALUOut.
- `ir_write`, `pc_write`, `reg_write`, `mem_write` — out — 1 each — write enables.
- `illegal` — out — 1 — unsupported opcode latched; sticky until reset.

## Operation
States and their outputs (unlisted enables are 0):
- **FETCH:** `adr_src`=0, A=00, B=10, add, `result_src`=10. `ir_write`=`pc_update`=`mem_ready`. Go to DECODE when `mem_ready`=1, else stay.
- **DECODE:** A=01, B=01, add (computes the branch target). Next state by `op`:
  - `0000011` or `0100011` → MEMADR
  - `0110011` → EXECUTER
  - `0010011` → EXECUTEI
  - `1101111` → JAL
  - `1100011` → BEQ
  - anything else → ILLEGAL
- **MEMADR:** A=10, B=01, add. Go to MEMREAD if `op[5]`=0, else MEMWRITE.
- **MEMREAD:** `result_src`=00, `adr_src`=1. Go to MEMWB when `mem_ready`=1.
- **MEMWB:** `result_src`=01, `reg_write`=1. Go to FETCH.
- **MEMWRITE:** `result_src`=00, `adr_src`=1, `mem_write`=1, held until `mem_ready`=1. Then go to FETCH.
- **EXECUTER:** A=10, B=00, `alu_op`=10. Go to ALUWB.
- **EXECUTEI:** A=10, B=01, `alu_op`=10. Go to ALUWB.
- **ALUWB:** `result_src`=00, `reg_write`=1. Go to FETCH.
- **JAL:** A=01, B=10, add, `result_src`=00, `pc_update`=1. Go to ALUWB.
- **BEQ:** A=10, B=00, sub, `result_src`=00, `branch`=1. Go to FETCH.
- **ILLEGAL:** all enables 0, `illegal`=1. Stays in ILLEGAL until reset.

`pc_write` = `pc_update` | (`branch` & `zero`).

ALU decode (`alu_op`):
- `00` → add
- `01` → sub
- `10` → by `funct3`:
  - `000` → sub if `op[5]` & `funct7b5`, else add
  - `010` → slt
  - `110` → or
  - `111` → and
  - other → add

`imm_src` is decoded from `op`:
- lw and I-ALU → 00
- sw → 01
- beq → 10
- jal → 11
- other → 00

## Timing
- Reset: state = FETCH, `illegal`=0. While `rst_n`=0, all four write enables are forced to 0 combinationally. After `rst_n` deasserts, the first edge with `mem_ready`=1 is a fetch.
- All outputs are a function of state plus `op`/`funct3`/`funct7b5`/`zero`/`mem_ready`. There are no registered outputs other than the state.
- Cycles per instruction with `mem_ready` held at 1:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - jal 4
  - beq 3
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Enables are not pulsed during a stall, except `mem_write`, which is held.
- Reset asserted mid-instruction: the state returns to FETCH asynchronously and enables drop in the same cycle.
- `zero` is sampled only in BEQ. `mem_ready` is ignored in all other states.

## Structure
- Shared package `riscv_pkg` holds:
  - ALU control codes (ADD/SUB/AND/OR/SLT = 000/001/010/011/101)
  - opcode constants
  - the `alu_op` codes
  - the state enum
  - the `alu_src_a`/`alu_src_b`/`result_src`/`imm_src` encodings
- One combinational sub-module, `alu_decoder` (`alu_op`, `funct3`, `op5`, `funct7b5` → `alu_control`). The FSM and the `imm_src` decode live in the top module.

## Test plan
- **Reset and fetch:** hold `rst_n`=0 with `mem_ready`=1 → all enables 0. Release, `op`=`0110011`, `funct3`=000, `funct7b5`=1 → `ir_write`=`pc_write`=1 in FETCH; `alu_control`=001 in EXECUTER; `reg_write`=1 on the 4th cycle.
- **lw with memory stall:** `op`=`0000011`, `mem_ready`=0 for 2 cycles in MEMREAD → MEMWB (`result_src`=01, `reg_write`=1) on cycle 7 and nothing written earlier. sw (`0100011`) → `mem_write`=1 held through the stall, `imm_src`=01.
- **beq:** `op`=`1100011` with `zero`=1 → `pc_write`=1 in cycle 3, `alu_control`=001. With `zero`=0 → `pc_write`=0 and the next state is FETCH.
- **jal then ALU-I:** jal → `pc_write`=1 in JAL, `reg_write` in ALUWB, `imm_src`=11. addi/ori/andi/slti (`funct3` 000/110/111/010) → `alu_control` 000/011/010/101, with `funct7b5`=1 not producing sub.
- **Illegal opcode:** `op`=`0000000` → ILLEGAL after DECODE, `illegal`=1, enables stay 0 for 10 cycles. Asserting `rst_n`=0 mid-MEMADR → FETCH immediately and `illegal`=0.
